// File: rtl/sprite_blit_sequencer.sv
// Per-frame sprite blitter: queues draw commands, replays them on each end-of-screen
// pulse, clips against the screen and emits sprite-read / VRAM-write addresses.
module sprite_blit_sequencer #(
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 180,
  parameter int SPRITE_SIZE       = 32,
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 15,
  parameter int SPRITE_IDX_WIDTH  = 4,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         i_screenend,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [SPRITE_IDX_WIDTH-1:0]  i_cmd_sprite,
  input  logic [10:0]                  i_cmd_x,
  input  logic [10:0]                  i_cmd_y,
  output logic [SPRITEBUF_A_WIDTH-1:0] o_address_s,
  output logic [VRAM_A_WIDTH-1:0]      o_address_screen,
  output logic                         o_is_layer_drawing,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_overrun
);

  localparam int SW = $clog2(SPRITE_SIZE);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int EW = SPRITE_IDX_WIDTH + 22;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
  state_t state, state_nx;

  // Command FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   count;
  logic          push, pop;

  assign o_cmd_ready = (count != (FW+1)'(FIFO_DEPTH));
  assign push        = i_cmd_valid && o_cmd_ready;
  assign pop         = (state == LOAD);

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {i_cmd_sprite, i_cmd_x, i_cmd_y};
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  logic [EW-1:0]               head;
  logic [SPRITE_IDX_WIDTH-1:0] head_sprite;
  logic signed [10:0]          head_x, head_y;

  assign head        = fifo_mem[rd_ptr];
  assign head_sprite = head[EW-1 -: SPRITE_IDX_WIDTH];
  assign head_x      = head[21:11];
  assign head_y      = head[10:0];

  // Clip window in sprite-local coordinates, computed wide and signed
  logic signed [31:0] hx, hy, c0, c1, r0, r1;
  logic               clip_empty;

  always_comb begin
    hx = 32'(head_x);
    hy = 32'(head_y);
    c0 = (hx < 0) ? -hx : 0;
    r0 = (hy < 0) ? -hy : 0;
    c1 = (SCREEN_WIDTH  - 1 - hx < SPRITE_SIZE - 1) ? SCREEN_WIDTH  - 1 - hx : SPRITE_SIZE - 1;
    r1 = (SCREEN_HEIGHT - 1 - hy < SPRITE_SIZE - 1) ? SCREEN_HEIGHT - 1 - hy : SPRITE_SIZE - 1;
    clip_empty = (c0 > c1) || (r0 > r1);
  end

  logic [SPRITE_IDX_WIDTH-1:0] cur_sprite;
  logic signed [10:0]          cur_x, cur_y;
  logic [SW-1:0]               row, col, col_start, col_end, row_end;
  logic [FW:0]                 remaining;
  logic                        last_pix, draw_q;

  assign last_pix = (row == row_end) && (col == col_end);

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_screenend && count != '0) state_nx = LOAD;
      LOAD: begin
        if (!clip_empty)                      state_nx = SCAN;
        else if (remaining != (FW+1)'(1))     state_nx = LOAD;
        else                                  state_nx = DONE;
      end
      SCAN: if (last_pix) state_nx = (remaining != '0) ? LOAD : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cur_sprite       <= '0;
      cur_x            <= '0;
      cur_y            <= '0;
      row              <= '0;
      col              <= '0;
      col_start        <= '0;
      col_end          <= '0;
      row_end          <= '0;
      remaining        <= '0;
      draw_q           <= 1'b0;
      o_address_screen <= '0;
      o_frame_done     <= 1'b0;
      o_overrun        <= 1'b0;
    end else begin
      o_frame_done <= (state == DONE) || (state == IDLE && i_screenend && count == '0);
      o_overrun    <= i_screenend && (state != IDLE);
      draw_q       <= (state == SCAN);
      if (state == SCAN)
        o_address_screen <= VRAM_A_WIDTH'((32'(cur_y) + $signed(32'(row))) * SCREEN_WIDTH
                                          + 32'(cur_x) + $signed(32'(col)));
      case (state)
        IDLE: if (i_screenend) remaining <= count;
        LOAD: begin
          remaining  <= remaining - 1'b1;
          cur_sprite <= head_sprite;
          cur_x      <= head_x;
          cur_y      <= head_y;
          row        <= SW'(r0);
          col        <= SW'(c0);
          col_start  <= SW'(c0);
          col_end    <= SW'(c1);
          row_end    <= SW'(r1);
        end
        SCAN: begin
          if (!last_pix) begin
            if (col == col_end) begin
              col <= col_start;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_address_s = SPRITEBUF_A_WIDTH'(32'(cur_sprite) * SPRITE_SIZE * SPRITE_SIZE
                                          + 32'(row) * SPRITE_SIZE + 32'(col));
  // Masked by rst so an aborted replay never strobes a write in the reset cycle
  assign o_is_layer_drawing = draw_q && !rst;
  assign o_busy             = (state != IDLE);

endmodule

// File: tb/tb_sprite_blit_sequencer.sv
// Directed bench for sprite_blit_sequencer: clipping, frame gating, FIFO full,
// overrun and mid-replay reset, with hand-computed addresses and cycle counts.
module tb_sprite_blit_sequencer;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        i_screenend = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [3:0]  i_cmd_sprite = '0;
  logic [10:0] i_cmd_x = '0;
  logic [10:0] i_cmd_y = '0;
  logic        o_cmd_ready;
  logic [14:0] o_address_s;
  logic [15:0] o_address_screen;
  logic        o_is_layer_drawing, o_busy, o_frame_done, o_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_blit_sequencer #(
    .SCREEN_WIDTH(320), .SCREEN_HEIGHT(180), .SPRITE_SIZE(32), .VRAM_A_WIDTH(16),
    .SPRITEBUF_A_WIDTH(15), .SPRITE_IDX_WIDTH(4), .FIFO_DEPTH(16)
  ) dut (
    .CLK(CLK), .rst(rst), .i_screenend(i_screenend),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_sprite(i_cmd_sprite), .i_cmd_x(i_cmd_x), .i_cmd_y(i_cmd_y),
    .o_address_s(o_address_s), .o_address_screen(o_address_screen),
    .o_is_layer_drawing(o_is_layer_drawing), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_cmd(input int spr, input int x, input int y);
    i_cmd_valid  = 1'b1;
    i_cmd_sprite = 4'(spr);
    i_cmd_x      = 11'(x);
    i_cmd_y      = 11'(y);
    tick();
    i_cmd_valid  = 1'b0;
  endtask

  // Pulses screenend and watches until o_frame_done. Cycle 1 is the cycle right
  // after the pulse. first/last_s pair each drawing cycle with the previous o_address_s.
  task automatic run_frame(output int draws, output int first_s, output int first_scr,
                           output int last_s, output int last_scr, output int first_cyc,
                           output int done_cyc, output int busy1);
    int cyc;
    int prev_s;
    bit done;
    draws = 0; first_s = -1; first_scr = -1; last_s = -1; last_scr = -1;
    first_cyc = -1; done = 1'b0; prev_s = -1;
    i_screenend = 1'b1;
    tick();
    i_screenend = 1'b0;
    cyc   = 1;
    busy1 = int'(o_busy);
    while (!done && cyc < 4000) begin
      if (o_is_layer_drawing) begin
        draws++;
        if (draws == 1) begin
          first_s   = prev_s;
          first_scr = int'(o_address_screen);
          first_cyc = cyc;
        end
        last_s   = prev_s;
        last_scr = int'(o_address_screen);
      end
      if (o_frame_done) done = 1'b1;
      else begin
        prev_s = int'(o_address_s);
        tick();
        cyc++;
      end
    end
    done_cyc = cyc;
    if (!done) check("frame_done_timeout", 32'(o_frame_done), 1);
  endtask

  int dr, fs, fscr, ls, lscr, fc, dc, b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy",       32'(o_busy), 0);
    check("rst_drawing",    32'(o_is_layer_drawing), 0);
    check("rst_frame_done", 32'(o_frame_done), 0);
    check("rst_overrun",    32'(o_overrun), 0);
    check("rst_addr_s",     32'(o_address_s), 0);
    check("rst_addr_scr",   32'(o_address_screen), 0);
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(o_cmd_ready), 1);

    // Single fully visible sprite
    push_cmd(1, 10, 20);
    run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
    check("vis_busy",      b1, 1);
    check("vis_first_cyc", fc, 3);
    check("vis_first_s",   fs, 1024);
    check("vis_first_scr", fscr, 6410);
    check("vis_last_s",    ls, 2047);
    check("vis_last_scr",  lscr, 16361);
    check("vis_draws",     dr, 1024);
    check("vis_done_cyc",  dc, 1027);
    check("vis_idle",      32'(o_busy), 0);

    // Left/bottom clip
    push_cmd(2, -5, 170);
    run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
    check("clip_first_s",   fs, 2053);
    check("clip_first_scr", fscr, 54400);
    check("clip_last_s",    ls, 2367);
    check("clip_last_scr",  lscr, 57306);
    check("clip_draws",     dr, 270);
    check("clip_done_cyc",  dc, 273);

    // Fully off-screen command followed by a visible one
    push_cmd(3, 320, 0);
    push_cmd(1, 0, 0);
    run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
    check("off_first_cyc", fc, 4);
    check("off_first_s",   fs, 1024);
    check("off_first_scr", fscr, 0);
    check("off_draws",     dr, 1024);
    check("off_done_cyc",  dc, 1028);

    // Frame gate: third command pushed mid-replay waits for the next frame
    push_cmd(4, 316, 176);
    push_cmd(5, -30, -30);
    fork
      run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
      begin
        repeat (5) tick();
        push_cmd(6, 0, -31);
      end
    join
    check("gate_first_s",   fs, 4096);
    check("gate_first_scr", fscr, 56636);
    check("gate_last_s",    ls, 6143);
    check("gate_last_scr",  lscr, 321);
    check("gate_draws",     dr, 20);
    check("gate_done_cyc",  dc, 24);
    run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
    check("gate2_first_s",   fs, 7136);
    check("gate2_first_scr", fscr, 0);
    check("gate2_last_s",    ls, 7167);
    check("gate2_last_scr",  lscr, 31);
    check("gate2_draws",     dr, 32);
    check("gate2_done_cyc",  dc, 35);

    // FIFO full, rejected 17th command, overrun during replay
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("full_ready_15", 32'(o_cmd_ready), 1);
      push_cmd(7, 0, 179);
    end
    check("full_ready_16", 32'(o_cmd_ready), 0);
    i_cmd_valid = 1'b1; i_cmd_sprite = 4'd8; i_cmd_x = 11'd0; i_cmd_y = 11'd0;
    repeat (3) tick();
    check("full_ready_held", 32'(o_cmd_ready), 0);
    i_cmd_valid = 1'b0;
    fork
      run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
      begin
        repeat (9) tick();
        i_screenend = 1'b1;
        tick();
        i_screenend = 1'b0;
        check("overrun_pulse", 32'(o_overrun), 1);
        tick();
        check("overrun_clear", 32'(o_overrun), 0);
      end
    join
    check("full_first_s",   fs, 7168);
    check("full_first_scr", fscr, 57280);
    check("full_last_s",    ls, 7199);
    check("full_last_scr",  lscr, 57311);
    check("full_draws",     dr, 512);
    check("full_done_cyc",  dc, 530);
    check("full_ready_after", 32'(o_cmd_ready), 1);

    // Reset mid-SCAN
    push_cmd(1, 0, 0);
    i_screenend = 1'b1;
    tick();
    i_screenend = 1'b0;
    repeat (5) tick();
    check("mid_drawing", 32'(o_is_layer_drawing), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_drawing", 32'(o_is_layer_drawing), 0);
    check("mid_rst_busy",    32'(o_busy), 0);
    rst = 1'b0;
    tick();
    check("mid_rst_ready",    32'(o_cmd_ready), 1);
    check("mid_rst_addr_s",   32'(o_address_s), 0);
    check("mid_rst_addr_scr", 32'(o_address_screen), 0);
    run_frame(dr, fs, fscr, ls, lscr, fc, dc, b1);
    check("empty_done_cyc", dc, 1);
    check("empty_draws",    dr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
